// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers, read-mode constants and parameter-legality check for
// the sync_fifo_flags family.
package sync_fifo_pkg;

    localparam int RD_STD  = 0;
    localparam int RD_FWFT = 1;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full FIFO (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_legal(input int depth, input int afull_th,
                                        input int aempty_th, input int fwft);
        return (depth >= 2) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth - 1) &&
               ((fwft == RD_STD) || (fwft == RD_FWFT));
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array: synchronous write port, asynchronous read port.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int ADDR_W     = addr_w(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; the array also has no reset so it maps onto RAM macros,
    // and the occupancy count alone decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and standard/FWFT read.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs with err_clr.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 16,
    parameter int AFULL_TH   = DATA_DEPTH - 2,
    parameter int AEMPTY_TH  = 2,
    parameter int FWFT       = RD_STD
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow,
`endif
    output logic [cnt_w(DATA_DEPTH)-1:0]  fifo_cnt
);

    localparam int ADDR_W = addr_w(DATA_DEPTH);
    localparam int CNT_W  = cnt_w(DATA_DEPTH);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0]  AFULL_CNT  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  AEMPTY_CNT = CNT_W'(AEMPTY_TH);

    if (!params_legal(DATA_DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("sync_fifo_flags: illegal DATA_DEPTH/AFULL_TH/AEMPTY_TH/FWFT combination");
    end

    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;

        // Explicit wrap so non-power-of-two depths never address past the end.
        if (wr_acc) begin
            wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign full         = (cnt_q == DEPTH_CNT);
    assign empty        = (cnt_q == '0);
    assign almost_full  = (cnt_q >= AFULL_CNT);
    assign almost_empty = (cnt_q <= AEMPTY_CNT);
    assign fifo_cnt     = cnt_q;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_addr_q),
        .wdata (data_in),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    if (FWFT == RD_FWFT) begin : g_fwft
        // Head word is always presented; a pop simply moves rd_addr on.
        assign data_out = ram_rdata;
        assign rd_valid = ~empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  rvalid_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dout_q   <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_acc;
                if (rd_acc) begin
                    dout_q <= ram_rdata;
                end
            end
        end

        assign data_out = dout_q;
        assign rd_valid = rvalid_q;
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    // Set term is OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (wr_en & full)  | (overflow_q  & ~err_clr);
            underflow_q <= (rd_en & empty) | (underflow_q & ~err_clr);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags: default standard FIFO, depth-5 wrap
// instance and an FWFT instance driven with directed vectors.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default instance: depth 16, standard read
    logic       s_wr, s_rd, s_rv, s_full, s_empty, s_af, s_ae;
    logic [7:0] s_din, s_dout;
    logic [4:0] s_cnt;
    // Depth 5 instance, standard read
    logic       d_wr, d_rd, d_rv, d_full, d_empty, d_af, d_ae;
    logic [7:0] d_din, d_dout;
    logic [3:0] d_cnt;
    // Depth 16 instance, first-word-fall-through
    logic       f_wr, f_rd, f_rv, f_full, f_empty, f_af, f_ae;
    logic [7:0] f_din, f_dout;
    logic [4:0] f_cnt;
`ifdef SYNC_FIFO_ERR_EN
    logic s_clr, s_ovf, s_unf, d_clr, d_ovf, d_unf, f_clr, f_ovf, f_unf;
`endif

    sync_fifo_flags u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd),
        .data_out(s_dout), .rd_valid(s_rv), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(s_clr), .overflow(s_ovf), .underflow(s_unf),
`endif
        .fifo_cnt(s_cnt)
    );

    sync_fifo_flags #(.DATA_DEPTH(5)) u_d5 (
        .clk(clk), .rst_n(rst_n), .wr_en(d_wr), .data_in(d_din), .rd_en(d_rd),
        .data_out(d_dout), .rd_valid(d_rv), .full(d_full), .empty(d_empty),
        .almost_full(d_af), .almost_empty(d_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(d_clr), .overflow(d_ovf), .underflow(d_unf),
`endif
        .fifo_cnt(d_cnt)
    );

    sync_fifo_flags #(.FWFT(1)) u_fw (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd),
        .data_out(f_dout), .rd_valid(f_rv), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr(f_clr), .overflow(f_ovf), .underflow(f_unf),
`endif
        .fifo_cnt(f_cnt)
    );

    logic [7:0] exp_std[$];
    logic [7:0] exp_d5[$];
    logic [7:0] exp_fw[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares read data whenever a DUT presents it, decoupled from stimulus.
    always @(negedge clk) begin
        if (s_rv === 1'b1) begin
            if (exp_std.size() == 0) check("std_unexpected_valid", s_rv, 0);
            else                     check("std_rd_data", s_dout, exp_std.pop_front());
        end
        if (d_rv === 1'b1) begin
            if (exp_d5.size() == 0) check("d5_unexpected_valid", d_rv, 0);
            else                    check("d5_rd_data", d_dout, exp_d5.pop_front());
        end
        if (f_rd === 1'b1 && f_rv === 1'b1) begin
            if (exp_fw.size() == 0) check("fw_unexpected_pop", f_rv, 0);
            else                    check("fw_head_data", f_dout, exp_fw.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic std_write(input logic [7:0] d);
        s_wr = 1'b1; s_din = d;
        step();
        s_wr = 1'b0;
    endtask

    task automatic std_read(input logic [7:0] d);
        s_rd = 1'b1;
        exp_std.push_back(d);
        step();
        s_rd = 1'b0;
        check("std_rd_valid_latency", s_rv, 1);
    endtask

    task automatic d5_write(input logic [7:0] d);
        d_wr = 1'b1; d_din = d;
        step();
        d_wr = 1'b0;
    endtask

    task automatic d5_read(input logic [7:0] d);
        d_rd = 1'b1;
        exp_d5.push_back(d);
        step();
        d_rd = 1'b0;
        check("d5_rd_valid_latency", d_rv, 1);
    endtask

    task automatic fw_write(input logic [7:0] d);
        f_wr = 1'b1; f_din = d;
        exp_fw.push_back(d);
        step();
        f_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        s_wr = 0; s_rd = 0; s_din = '0;
        d_wr = 0; d_rd = 0; d_din = '0;
        f_wr = 0; f_rd = 0; f_din = '0;
`ifdef SYNC_FIFO_ERR_EN
        s_clr = 0; d_clr = 0; f_clr = 0;
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset / idle state
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_ae, 1);
        check("rst_full", s_full, 0);
        check("rst_afull", s_af, 0);
        check("rst_cnt", s_cnt, 0);
        check("rst_rd_valid", s_rv, 0);
        check("rst_data_out", s_dout, 0);
        check("rst_fw_rd_valid", f_rv, 0);

        // Fill 16 words, watch thresholds, then overflow attempt
        for (int i = 1; i <= 16; i++) begin
            std_write(8'(i));
            check("fill_cnt", s_cnt, i);
            check("fill_afull", s_af, (i >= 14));
            check("fill_aempty", s_ae, (i <= 2));
            check("fill_full", s_full, (i == 16));
        end
        std_write(8'hAA);
        check("ovf_write_cnt", s_cnt, 16);
        check("ovf_write_full", s_full, 1);

        for (int i = 1; i <= 16; i++) begin
            std_read(8'(i));
            check("drain_cnt", s_cnt, 16 - i);
        end
        step();
        check("drain_rd_valid_drop", s_rv, 0);
        check("drain_empty", s_empty, 1);
        check("drain_dout_hold", s_dout, 8'h10);

        // Simultaneous write+read when full: read wins, data_in dropped
        for (int i = 0; i < 16; i++) std_write(8'(8'h20 + i));
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hBB;
        exp_std.push_back(8'h20);
        step();
        s_wr = 1'b0; s_rd = 1'b0;
        check("simul_full_cnt", s_cnt, 15);
        check("simul_full_flag", s_full, 0);
        for (int i = 1; i < 16; i++) std_read(8'(8'h20 + i));
        check("simul_full_drained", s_empty, 1);

        // Simultaneous write+read when empty: write wins, no read data
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hCC;
        step();
        s_wr = 1'b0; s_rd = 1'b0;
        check("simul_empty_cnt", s_cnt, 1);
        check("simul_empty_rd_valid", s_rv, 0);

        // Simultaneous write+read at count 7: count unchanged
        for (int i = 1; i <= 6; i++) std_write(8'(8'hC0 + i));
        check("mid_cnt", s_cnt, 7);
        s_wr = 1'b1; s_rd = 1'b1; s_din = 8'hC7;
        exp_std.push_back(8'hCC);
        step();
        s_wr = 1'b0; s_rd = 1'b0;
        check("simul_mid_cnt", s_cnt, 7);
        for (int i = 1; i <= 7; i++) std_read(8'(8'hC0 + i));
        check("simul_mid_empty", s_empty, 1);

        // Depth 5: pointer wrap across three rounds
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                d5_write(8'(r * 16 + k + 1));
                check("d5_cnt_fill", d_cnt, k + 1);
            end
            check("d5_full", d_full, 0);
            check("d5_afull", d_af, 1);
            for (int k = 0; k < 4; k++) d5_read(8'(r * 16 + k + 1));
            check("d5_empty", d_empty, 1);
        end

        // FWFT: word appears the cycle after the write with no rd_en
        fw_write(8'h5A);
        check("fw_rd_valid", f_rv, 1);
        check("fw_data_out", f_dout, 8'h5A);
        step();
        check("fw_hold_data", f_dout, 8'h5A);
        f_rd = 1'b1;
        step();
        f_rd = 1'b0;
        check("fw_pop_rd_valid", f_rv, 0);
        check("fw_pop_empty", f_empty, 1);
        fw_write(8'h11);
        fw_write(8'h22);
        fw_write(8'h33);
        check("fw_cnt3", f_cnt, 3);
        f_rd = 1'b1;
        step();
        step();
        step();
        f_rd = 1'b0;
        check("fw_stream_empty", f_empty, 1);

        // Reset mid-operation with a write pending
        for (int i = 1; i <= 9; i++) std_write(8'(8'h90 + i));
        check("pre_rst_cnt", s_cnt, 9);
        s_wr = 1'b1; s_din = 8'hEE; rst_n = 1'b0;
        step();
        rst_n = 1'b1; s_wr = 1'b0;
        check("midrst_cnt", s_cnt, 0);
        check("midrst_empty", s_empty, 1);
        check("midrst_rd_valid", s_rv, 0);
        std_write(8'h77);
        std_read(8'h77);

`ifdef SYNC_FIFO_ERR_EN
        check("err_ovf_after_rst", s_ovf, 0);
        s_rd = 1'b1;
        step();
        s_rd = 1'b0;
        check("err_unf_set", s_unf, 1);
        step();
        check("err_unf_sticky", s_unf, 1);
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        check("err_unf_clr", s_unf, 0);
        s_clr = 1'b1; s_rd = 1'b1;
        step();
        s_clr = 1'b0; s_rd = 1'b0;
        check("err_unf_set_wins", s_unf, 1);
`endif

        step();
        step();
        check("std_sb_drained", exp_std.size(), 0);
        check("d5_sb_drained", exp_d5.size(), 0);
        check("fw_sb_drained", exp_fw.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
